// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with load, wrap/saturate, terminal-count pulse and sticky ovf.
// Optional count prescaler is compiled in when CNT_PRESCALE_EN is defined.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH) || PRESCALE < 2) begin : g_bad_params
    $error("param_updown_counter: illegal parameter combination");
  end

  // Out-of-range load values are pulled down to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v > MAX_VAL) begin
      return MAX_VAL;
    end else begin
      return v;
    end
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             ovf_r;
  logic             ovf_next_s;
  logic             tick_s;
  logic             at_bound_s;
  logic             bstep_s;

`ifdef CNT_PRESCALE_EN
  localparam int            PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_next_s;

  // A count step happens only on the last enabled cycle of each prescale period.
  always_comb begin
    tick_s = en & (pre_r == PRE_LAST);
  end

  // Prescaler next state: load restarts the period, en advances it.
  always_comb begin
    pre_next_s = pre_r;
    if (load) begin
      pre_next_s = {PW{1'b0}};
    end else if (en) begin
      if (pre_r == PRE_LAST) begin
        pre_next_s = {PW{1'b0}};
      end else begin
        pre_next_s = pre_r + PW'(1);
      end
    end else begin
      pre_next_s = pre_r;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PW{1'b0}};
    end else begin
      pre_r <= pre_next_s;
    end
  end
`else
  // Without the prescaler every enabled cycle is a step.
  always_comb begin
    tick_s = en;
  end
`endif

  // Boundary detection and the terminal-count pulse; compare-based so a full-range modulus works too.
  always_comb begin
    if (up_dn) begin
      at_bound_s = (q_r == MAX_VAL);
    end else begin
      at_bound_s = (q_r == {WIDTH{1'b0}});
    end
    bstep_s = tick_s & ~load & ~rst & at_bound_s;
  end

  // Count next state: load beats stepping; boundary steps wrap or hold.
  always_comb begin
    q_next_s = q_r;
    if (load) begin
      q_next_s = clamp_load(load_val);
    end else if (tick_s) begin
      if (at_bound_s) begin
        if (sat_mode) begin
          q_next_s = q_r;
        end else if (up_dn) begin
          q_next_s = {WIDTH{1'b0}};
        end else begin
          q_next_s = MAX_VAL;
        end
      end else if (up_dn) begin
        q_next_s = q_r + WIDTH'(1);
      end else begin
        q_next_s = q_r - WIDTH'(1);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Sticky overflow: a boundary step beats a simultaneous clear.
  always_comb begin
    ovf_next_s = ovf_r;
    if (bstep_s) begin
      ovf_next_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= {WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      ovf_r <= ovf_next_s;
    end
  end

  assign Q   = q_r;
  assign ovf = ovf_r;
  assign tc  = bstep_s;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter at WIDTH=4, MODULUS=10.
// Builds with CNT_PRESCALE_EN defined run the prescaler sequence instead of the plain sequence.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       sat_mode;
  logic       clr_ovf;
  logic [3:0] Q;
  logic       tc;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .sat_mode(sat_mode), .clr_ovf(clr_ovf), .Q(Q), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the combinational tc with current inputs, then advance one edge.
  task automatic cyc(input string tag, input logic exp_tc);
    #1;
    chk({tag, " tc"}, {31'd0, tc}, {31'd0, exp_tc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    cyc("load", 1'b0);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    sat_mode = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset Q", {28'd0, Q}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    chk("reset tc", {31'd0, tc}, 32'd0);

`ifndef CNT_PRESCALE_EN
    // 1: count up through the wrap
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up Q[%0d]", i), {28'd0, Q}, i % 10);
      cyc($sformatf("up[%0d]", i), (i == 9));
      chk($sformatf("up ovf[%0d]", i), {31'd0, ovf}, (i >= 9) ? 32'd1 : 32'd0);
    end
    chk("up final Q", {28'd0, Q}, 32'd2);

    // 2: load 3 then count down through the wrap; then clamped load
    do_load(4'd3);
    en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dn Q[%0d]", i), {28'd0, Q}, (13 - i) % 10);
      cyc($sformatf("dn[%0d]", i), (i == 3));
    end
    chk("dn final Q", {28'd0, Q}, 32'd8);
    do_load(4'd12);
    chk("clamp Q", {28'd0, Q}, 32'd9);

    // clear ovf with no boundary step
    clr_ovf = 1'b1;
    cyc("clr", 1'b0);
    clr_ovf = 1'b0;
    chk("clr ovf", {31'd0, ovf}, 32'd0);

    // 3: saturate at the top, then step down
    sat_mode = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("sat[%0d]", i), 1'b1);
      chk($sformatf("sat Q[%0d]", i), {28'd0, Q}, 32'd9);
    end
    chk("sat ovf", {31'd0, ovf}, 32'd1);
    up_dn = 1'b0;
    cyc("sat dn", 1'b0);
    chk("sat dn Q", {28'd0, Q}, 32'd8);
    sat_mode = 1'b0;

    // 4: clear coinciding with a down wrap loses to set; clear alone works
    do_load(4'd0);
    en = 1'b1; up_dn = 1'b0; clr_ovf = 1'b1;
    cyc("clr+wrap", 1'b1);
    chk("clr+wrap Q", {28'd0, Q}, 32'd9);
    chk("clr+wrap ovf", {31'd0, ovf}, 32'd1);
    en = 1'b0;
    cyc("clr only", 1'b0);
    clr_ovf = 1'b0;
    chk("clr only ovf", {31'd0, ovf}, 32'd0);

    // 5: reset beats load and step; load beats step, even at a boundary
    do_load(4'd9);
    en = 1'b1; up_dn = 1'b1;
    cyc("pre-rst wrap", 1'b1);
    chk("pre-rst ovf", {31'd0, ovf}, 32'd1);
    do_load(4'd5);
    chk("pre-rst Q", {28'd0, Q}, 32'd5);
    en = 1'b1; rst = 1'b1; load = 1'b1; load_val = 4'd7;
    cyc("rst+load", 1'b0);
    rst = 1'b0;
    chk("rst+load Q", {28'd0, Q}, 32'd0);
    chk("rst+load ovf", {31'd0, ovf}, 32'd0);
    cyc("load+en", 1'b0);
    chk("load+en Q", {28'd0, Q}, 32'd7);
    load_val = 4'd9;
    cyc("load 9", 1'b0);
    load_val = 4'd4;
    cyc("load at bound", 1'b0);
    load = 1'b0;
    chk("load at bound Q", {28'd0, Q}, 32'd4);
    chk("load at bound ovf", {31'd0, ovf}, 32'd0);
`else
    // 6: one step per four enabled cycles; load restarts the period
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pre Q[%0d]", i), {28'd0, Q}, i / 4);
      cyc($sformatf("pre[%0d]", i), 1'b0);
    end
    chk("pre final Q", {28'd0, Q}, 32'd2);
    cyc("pre mid0", 1'b0);
    cyc("pre mid1", 1'b0);
    en = 1'b1; load = 1'b1; load_val = 4'd5;
    cyc("pre load", 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("pre rs[%0d]", i), 1'b0);
      chk($sformatf("pre rs Q[%0d]", i), {28'd0, Q}, 32'd5);
    end
    cyc("pre rs step", 1'b0);
    chk("pre rs step Q", {28'd0, Q}, 32'd6);
    do_load(4'd9);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("pre bnd[%0d]", i), (i == 3));
    end
    chk("pre bnd Q", {28'd0, Q}, 32'd0);
    chk("pre bnd ovf", {31'd0, ovf}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
